// File: rtl/int_alu_arbiter_pkg.sv
// Shared types and constants for the round-robin integer ALU arbiter.
package int_alu_arbiter_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_SHFTL   = 3'd2,
        OP_SHFTR   = 3'd3,
        OP_AND     = 3'd4,
        OP_OR      = 3'd5,
        OP_XOR     = 3'd6,
        OP_ILLEGAL = 3'd7
    } alu_op_t;

    localparam int          DATA_W     = 32;
    localparam logic [31:0] ALU_POISON = 32'hDEAD_DEAD;

endpackage

// File: rtl/int_alu_arbiter_alu.sv
// Integer ALU: purely combinational, flags illegal opcodes with a poison result.
module intalu
    import int_alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] y,
    output logic              err
);

    // Opcode decode; shifts use only the low five bits of B.
    always_comb begin
        y   = 32'd0;
        err = 1'b0;
        case (op)
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_SHFTL: y = a << b[4:0];
            OP_SHFTR: y = a >> b[4:0];
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            default: begin
                y   = ALU_POISON;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/int_alu_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int pos;

    // Scan from ptr upward modulo NUM_REQ and keep the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[pos]) begin
                any       = 1'b1;
                grant[pos] = 1'b1;
                grant_idx = pos[IDX_W-1:0];
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/int_alu_arbiter.sv
// Shares one integer ALU between NUM_REQ requesters through a two-stage
// (issue, result) pipeline with round-robin grant and tagged, backpressured results.
module int_alu_arbiter
    import int_alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_a,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_b,
    input  logic [NUM_REQ-1:0][2:0]           req_op,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [DATA_W-1:0]                 rsp_y,
    output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
    output logic [TAG_W-1:0]                  rsp_tag,
    output logic                              rsp_err,
    output logic                              idle
);

    localparam int               ID_W     = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;

    logic               s1_valid;
    logic [DATA_W-1:0]  s1_a;
    logic [DATA_W-1:0]  s1_b;
    alu_op_t            s1_op;
    logic [TAG_W-1:0]   s1_tag;
    logic [ID_W-1:0]    s1_id;

    logic [DATA_W-1:0]  alu_y;
    logic               alu_err;

    logic               s2_adv;
    logic               s1_adv;
    logic               accept;
    logic               transfer;

    // rsp_valid is the stage-2 occupancy flag itself.
    assign s2_adv    = !rsp_valid || rsp_ready;
    assign s1_adv    = s1_valid && s2_adv;
    assign accept    = !s1_valid || s2_adv;
    assign transfer  = grant_any && accept;
    assign req_ready = grant & {NUM_REQ{accept}};
    assign idle      = !s1_valid && !rsp_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    intalu u_alu (
        .a   (s1_a),
        .b   (s1_b),
        .op  (s1_op),
        .y   (alu_y),
        .err (alu_err)
    );

    // Round-robin pointer moves just past the winner on every transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_W'(1);
        end
    end

    // Issue register: loads the granted payload, empties when it moves on with nothing behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
            s1_tag   <= '0;
            s1_id    <= '0;
        end else if (transfer) begin
            s1_valid <= 1'b1;
            s1_a     <= req_a[grant_idx];
            s1_b     <= req_b[grant_idx];
            s1_op    <= alu_op_t'(req_op[grant_idx]);
            s1_tag   <= req_tag[grant_idx];
            s1_id    <= grant_idx;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Result register: reloads on s1_adv even while the consumer drains, so no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
        end else if (s1_adv) begin
            rsp_valid <= 1'b1;
            rsp_y     <= alu_y;
            rsp_id    <= s1_id;
            rsp_tag   <= s1_tag;
            rsp_err   <= alu_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_int_alu_arbiter.sv
// Self-checking bench: queue-level reference model plus directed literal checks.
module tb_int_alu_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][31:0]    req_a;
    logic [N-1:0][31:0]    req_b;
    logic [N-1:0][2:0]     req_op;
    logic [N-1:0][TW-1:0]  req_tag;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_y;
    logic [IW-1:0]         rsp_id;
    logic [TW-1:0]         rsp_tag;
    logic                  rsp_err;
    logic                  idle;

    int_alu_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .idle      (idle)
    );

    typedef struct {
        logic [31:0]   y;
        logic          err;
        int            id;
        logic [TW-1:0] tag;
        int            age;
    } ent_t;

    // Reference model: in-flight ops in acceptance order, and the round-robin start point.
    ent_t pipe[$];
    int   m_ptr;

    int errors = 0;
    int checks = 0;

    bit        rand_mode = 1'b0;
    bit        keep      = 1'b0;
    logic [N-1:0] acc;

    logic [N-1:0]  obs_ready;
    logic          obs_rv;
    logic [31:0]   obs_y;
    logic [IW-1:0] obs_id;
    logic [TW-1:0] obs_tag;
    logic          obs_err;

    function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a + b};
            3'd1:    return {1'b0, a - b};
            3'd2:    return {1'b0, a << b[4:0]};
            3'd3:    return {1'b0, a >> b[4:0]};
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, a | b};
            3'd6:    return {1'b0, a ^ b};
            default: return {1'b1, 32'hDEADDEAD};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic new_payload(input int i);
        req_valid[i] = 1'b1;
        req_a[i]     = $urandom;
        req_b[i]     = $urandom;
        req_op[i]    = 3'($urandom_range(0, 7));
        req_tag[i]   = TW'($urandom);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (keep) new_payload(i);
                else req_valid[i] = 1'b0;
            end
            if (rand_mode && !req_valid[i] && $urandom_range(0, 99) < 50) new_payload(i);
        end
        if (rand_mode) rsp_ready = ($urandom_range(0, 99) < 70);
    endtask

    // One clock: compare at negedge against the model, advance the model, then drive after posedge.
    task automatic step();
        int          n;
        int          g;
        bit          can_take;
        bit          exp_rv;
        logic [N-1:0] exp_ready;
        logic [32:0] r;
        ent_t        e;
        @(negedge clk);
        n        = pipe.size();
        can_take = (n < 2) || rsp_ready;
        g        = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (g < 0 && req_valid[j]) g = j;
        end
        exp_ready = (g >= 0 && can_take) ? N'(1 << g) : '0;
        exp_rv    = (n > 0) && (pipe[0].age >= 1);
        obs_ready = req_ready;
        obs_rv    = rsp_valid;
        obs_y     = rsp_y;
        obs_id    = rsp_id;
        obs_tag   = rsp_tag;
        obs_err   = rsp_err;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("idle", 64'(idle), 64'(n == 0));
        if (exp_rv) begin
            check("rsp_y", 64'(rsp_y), 64'(pipe[0].y));
            check("rsp_id", 64'(rsp_id), 64'(pipe[0].id));
            check("rsp_tag", 64'(rsp_tag), 64'(pipe[0].tag));
            check("rsp_err", 64'(rsp_err), 64'(pipe[0].err));
        end
        acc = exp_ready;
        if (exp_rv && rsp_ready) void'(pipe.pop_front());
        foreach (pipe[q]) pipe[q].age++;
        if (exp_ready != '0) begin
            r     = ref_alu(req_a[g], req_b[g], req_op[g]);
            e.y   = r[31:0];
            e.err = r[32];
            e.id  = g;
            e.tag = req_tag[g];
            e.age = 0;
            pipe.push_back(e);
            m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain();
        int cnt;
        rand_mode = 1'b0;
        keep      = 1'b0;
        rsp_ready = 1'b1;
        cnt       = 0;
        while ((req_valid != '0 || pipe.size() != 0) && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    task automatic run_single(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [TW-1:0] tag,
                              input logic [31:0] exp_y, input logic exp_err,
                              output int latency, output logic [IW-1:0] id_seen,
                              output logic [TW-1:0] tag_seen);
        int acc_cyc;
        int rsp_cyc;
        logic [31:0] y_seen;
        logic        err_seen;
        drain();
        req_a[0]     = a;
        req_b[0]     = b;
        req_op[0]    = op;
        req_tag[0]   = tag;
        req_valid[0] = 1'b1;
        acc_cyc  = -1;
        rsp_cyc  = -1;
        y_seen   = '0;
        err_seen = 1'b0;
        id_seen  = '0;
        tag_seen = '0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (obs_ready[0] && acc_cyc < 0) acc_cyc = c;
            if (obs_rv && rsp_cyc < 0) begin
                rsp_cyc  = c;
                y_seen   = obs_y;
                err_seen = obs_err;
                id_seen  = obs_id;
                tag_seen = obs_tag;
            end
        end
        check({name, "_seen"}, 64'(rsp_cyc >= 0), 64'(1));
        check({name, "_y"}, 64'(y_seen), 64'(exp_y));
        check({name, "_err"}, 64'(err_seen), 64'(exp_err));
        latency = rsp_cyc - acc_cyc;
    endtask

    int            lat;
    logic [IW-1:0] sid;
    logic [TW-1:0] stag;
    int            nacc;
    int            ids[$];
    int            grant_seq[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_tag   = '0;
        acc       = '0;
        m_ptr     = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_y", 64'(rsp_y), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_tag", 64'(rsp_tag), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All four requesters continuously valid: strict rotation.
        rsp_ready = 1'b1;
        keep      = 1'b1;
        for (int i = 0; i < N; i++) new_payload(i);
        for (int k = 0; k < 6; k++) begin
            step();
            check("grant_order", 64'(obs_ready), 64'(1 << grant_seq[k]));
        end
        drain();

        // Single ADD with latency and echo checks, then arithmetic corners.
        run_single("add", 32'd5, 32'd7, 3'd0, 4'd3, 32'd12, 1'b0, lat, sid, stag);
        check("add_latency", 64'(lat), 64'(2));
        check("add_id", 64'(sid), 64'(0));
        check("add_tag", 64'(stag), 64'(3));
        run_single("sub", 32'd0, 32'd1, 3'd1, 4'd1, 32'hFFFF_FFFF, 1'b0, lat, sid, stag);
        run_single("shl", 32'd1, 32'd33, 3'd2, 4'd2, 32'h2, 1'b0, lat, sid, stag);
        run_single("shr", 32'h8000_0000, 32'd31, 3'd3, 4'd4, 32'h1, 1'b0, lat, sid, stag);
        run_single("xor", 32'hF0F0_F0F0, 32'hFFFF_0000, 3'd6, 4'd5, 32'h0F0F_F0F0, 1'b0, lat, sid, stag);
        run_single("illegal", 32'd9, 32'd9, 3'd7, 4'd6, 32'hDEAD_DEAD, 1'b1, lat, sid, stag);
        run_single("after_illegal", 32'hC, 32'hA, 3'd5, 4'd7, 32'hE, 1'b0, lat, sid, stag);

        // Stall: consumer blocked, three requesters pending.
        drain();
        rsp_ready = 1'b0;
        for (int i = 1; i < N; i++) new_payload(i);
        nacc = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (obs_ready != '0) nacc++;
        end
        check("stall_accepts", 64'(nacc), 64'(2));
        check("stall_ready", 64'(obs_ready), 64'(0));
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (obs_rv) ids.push_back(int'(obs_id));
        end
        check("stall_rsp_count", 64'(ids.size()), 64'(3));
        if (ids.size() == 3) begin
            check("stall_order0", 64'(ids[0]), 64'(1));
            check("stall_order1", 64'(ids[1]), 64'(2));
            check("stall_order2", 64'(ids[2]), 64'(3));
        end

        // Reset with both stages full, pointer parked at 2.
        drain();
        rsp_ready = 1'b0;
        new_payload(0);
        new_payload(1);
        repeat (3) step();
        check("prefill_full", 64'(pipe.size()), 64'(2));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("async_rst_idle", 64'(idle), 64'(1));
        pipe.delete();
        m_ptr     = 0;
        req_valid = '0;
        acc       = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        new_payload(0);
        new_payload(2);
        step();
        check("post_rst_grant", 64'(obs_ready), 64'(4'b0001));
        drain();

        // Randomized traffic against the model.
        rand_mode = 1'b1;
        keep      = 1'b0;
        repeat (500) step();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
